data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Single-cycle data memory stage directly downstream of the ALU; the ALU result drives addr.
//   Supports RISC-V loads LB/LH/LW/LBU/LHU and stores SB/SH/SW, little-endian.
//   Writes are synchronous; reads are combinational so loads complete in the same cycle.
//   Flags misaligned or illegal accesses, suppresses them, and holds a sticky fault record.
// PARAMETERS
//   N       32  data and address width; only N=32 is supported
//   DEPTH   64  number of 32-bit words; must be a power of 2
//   ADDR_W  6   log2(DEPTH); word index is addr[ADDR_W+1:2]
// PORTS
//   clk          in   1  clock; all state updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset
//   addr         in   N  byte address (the ALU out)
//   wdata        in   N  store data; the byte/half is taken from the LSBs
//   mem_read     in   1  load request
//   mem_write    in   1  store request
//   funct3       in   3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   fault_clr    in   1  clears the sticky fault record
//   rdata        out  N  load result, already extended
//   misaligned   out  1  combinational: current access is misaligned or illegal
//   fault_sticky out  1  registered: a fault has occurred since reset or the last clear
//   fault_addr   out  N  registered: addr of the first fault since reset or the last clear
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - all DEPTH words = 0; fault_sticky = 0; fault_addr = 0.
//     - A store in flight when reset asserts is lost.
//   Addressing:
//     - Word index = addr[ADDR_W+1:2]; higher bits are ignored, so addresses wrap modulo 4*DEPTH.
//     - Byte lane = addr[1:0]; lane 0 is bits [7:0].
//   Faults, with act = mem_read|mem_write:
//     - misaligned = act & (illegal funct3 (011,110,111), or H/HU with addr[0]=1, or W with addr[1:0]!=0).
//     - When act=0, misaligned=0.
//   Store (at posedge, when mem_write=1 and misaligned=0):
//     - SB writes lane addr[1:0].
//     - SH writes lanes {addr[1],0} and {addr[1],1}.
//     - SW writes all 4 lanes; other lanes keep their values.
//     - funct3 100/101 with mem_write are illegal.
//   Load (combinational, 0 cycles latency):
//     - If mem_read=0 or misaligned=1: rdata = 0.
//     - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: whole word.
//   Read and write in the same cycle:
//     - rdata shows the pre-write contents (read-before-write).
//     - New data is visible after the edge.
//   Sticky fault (at posedge):
//     - If misaligned=1: fault_sticky <= 1.
//     - fault_addr <= addr only if fault_sticky was 0 (the first fault is kept).
//     - Else if fault_clr=1: fault_sticky <= 0 and fault_addr <= 0.
//     - Fault and fault_clr in the same cycle: the fault wins, and its addr is captured as the new first fault.
//   No other state. No handshake: a request is valid for exactly the cycle it is presented.
// TESTING
//   - Reset, then LW at 0x0, 0x40, 0xFC -> rdata=0; fault_sticky=0; fault_addr=0.
//   - SW 0x8000_00F1 at 0x10, then:
//       LB 0x10 -> 0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1;
//       LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000.
//   - SW 0xAABBCCDD at 0x20; SB 0x11 at 0x21; SH 0x2233 at 0x22 -> LW 0x20 = 0x223311DD.
//   - SW 0x5 at 0x102 -> misaligned=1, no write.
//       Sticky fault state: fault_sticky=1, fault_addr=0x102.
//       A later LH at 0x3 keeps fault_addr=0x102.
//       fault_clr -> sticky=0.
//   - Wrap and read-before-write:
//       SW 0x1234 at 0x100 (DEPTH=64) aliases word 0: LW 0x0 = 0x1234.
//       Same-cycle LW+SW 0x9 at 0x0: rdata=0x1234, then 0x9 next cycle.
//   - Reset and fault/clear races:
//       rst_n low mid-cycle during SW 0x77 at 0x8 -> LW 0x8 = 0 after release.
//       Fault + fault_clr in the same cycle -> sticky=1 with the new addr.

Source files
------------

// File: rtl/data_memory.sv
// Single-cycle little-endian data memory for RISC-V loads/stores: synchronous byte-lane
// writes, combinational extended reads, misalignment/illegal-op detection and a sticky fault record.
module data_memory #(
   parameter int N      = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] addr,
   input  logic [N-1:0] wdata,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [2:0]   funct3,
   input  logic         fault_clr,
   output logic [N-1:0] rdata,
   output logic         misaligned,
   output logic         fault_sticky,
   output logic [N-1:0] fault_addr
);

   logic [N-1:0]      r_mem [DEPTH];
   logic              r_fault_sticky;
   logic [N-1:0]      r_fault_addr;

   logic              w_act;
   logic              w_bad;
   logic              w_we;
   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic [N-1:0]      w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [3:0]        w_be;
   logic [N-1:0]      w_wd;
   logic              w_unused;

   assign w_act    = mem_read | mem_write;
   assign w_idx    = addr[ADDR_W+1:2];
   assign w_lane   = addr[1:0];
   assign w_unused = ^addr[N-1:ADDR_W+2];

   // Unsigned sizes are only meaningful for loads, so a store with BU/HU is rejected.
   always_comb begin
      w_bad = 1'b1;
      case (funct3)
         3'b000:  w_bad = 1'b0;
         3'b001:  w_bad = addr[0];
         3'b010:  w_bad = |addr[1:0];
         3'b100:  w_bad = mem_write;
         3'b101:  w_bad = mem_write | addr[0];
         default: w_bad = 1'b1;
      endcase
   end

   assign misaligned = w_act & w_bad;
   assign w_we       = mem_write & ~misaligned;

   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_lane, 3'b000} +: 8];
   assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

   always_comb begin
      rdata = '0;
      if (mem_read && !misaligned) begin
         case (funct3)
            3'b000:  rdata = {{(N-8){w_byte[7]}}, w_byte};
            3'b001:  rdata = {{(N-16){w_half[15]}}, w_half};
            3'b010:  rdata = w_word;
            3'b100:  rdata = {{(N-8){1'b0}}, w_byte};
            3'b101:  rdata = {{(N-16){1'b0}}, w_half};
            default: rdata = '0;
         endcase
      end
   end

   // Store data is replicated across lanes so each enabled lane just picks its own slice.
   always_comb begin
      w_be = 4'b0000;
      w_wd = '0;
      case (funct3[1:0])
         2'b00: begin
            w_be = 4'b0001 << w_lane;
            w_wd = {4{wdata[7:0]}};
         end
         2'b01: begin
            w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{wdata[15:0]}};
         end
         2'b10: begin
            w_be = 4'b1111;
            w_wd = wdata;
         end
         default: begin
            w_be = 4'b0000;
            w_wd = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
         end
      end
   end

   // A fault that coincides with a clear restarts the record with the new address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_sticky <= 1'b0;
         r_fault_addr   <= '0;
      end else if (misaligned) begin
         r_fault_sticky <= 1'b1;
         if (!r_fault_sticky || fault_clr) begin
            r_fault_addr <= addr;
         end
      end else if (fault_clr) begin
         r_fault_sticky <= 1'b0;
         r_fault_addr   <= '0;
      end
   end

   assign fault_sticky = r_fault_sticky;
   assign fault_addr   = r_fault_addr;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a byte-array reference model predicts every cycle's
// load data, fault flag and sticky record; a negedge monitor pops and compares.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata, rdata, fault_addr;
   logic        mem_read, mem_write, fault_clr, misaligned, fault_sticky;
   logic [2:0]  funct3;

   data_memory dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .fault_clr(fault_clr), .rdata(rdata), .misaligned(misaligned),
      .fault_sticky(fault_sticky), .fault_addr(fault_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] rd;
      logic        mis;
      logic        st;
      logic [31:0] fa;
   } exp_t;

   exp_t        q[$];
   int          nchecks = 0;
   int          nerrors = 0;

   // reference model: 256 bytes (4*DEPTH), addresses wrap modulo 256
   logic [7:0]  m_mem [256];
   logic        m_sticky;
   logic [31:0] m_faddr;

   // store/fault effect awaiting the next rising edge
   logic        p_v, p_wr, p_mis, p_clr;
   logic [2:0]  p_f3;
   logic [31:0] p_a, p_wd;

   function automatic logic f_mis(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
      if (!(rd || wr)) return 1'b0;
      case (f3)
         3'd0:    return 1'b0;
         3'd1:    return a[0];
         3'd2:    return a[1:0] != 2'b00;
         3'd4:    return wr;
         3'd5:    return wr || a[0];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] f_load(logic rd, logic mis, logic [2:0] f3, logic [31:0] a);
      logic [7:0]  b0;
      logic [31:0] v;
      b0 = a[7:0];
      if (!rd || mis) return 32'h0;
      v = {m_mem[8'(b0+3)], m_mem[8'(b0+2)], m_mem[8'(b0+1)], m_mem[b0]};
      case (f3)
         3'd0:    return 32'($signed(v[7:0]));
         3'd1:    return 32'($signed(v[15:0]));
         3'd2:    return v;
         3'd4:    return {24'h0, v[7:0]};
         3'd5:    return {16'h0, v[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic apply_pending();
      logic [7:0] b0;
      b0 = p_a[7:0];
      if (p_wr && !p_mis) begin
         m_mem[b0] = p_wd[7:0];
         if (p_f3 == 3'd1 || p_f3 == 3'd2) m_mem[8'(b0+1)] = p_wd[15:8];
         if (p_f3 == 3'd2) begin
            m_mem[8'(b0+2)] = p_wd[23:16];
            m_mem[8'(b0+3)] = p_wd[31:24];
         end
      end
      if (p_mis) begin
         if (!m_sticky || p_clr) m_faddr = p_a;
         m_sticky = 1'b1;
      end else if (p_clr) begin
         m_sticky = 1'b0;
         m_faddr  = 32'h0;
      end
      p_v = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_sticky = 1'b0;
      m_faddr  = 32'h0;
      p_v      = 1'b0;
   endtask

   task automatic drive_idle();
      addr = 32'h0; wdata = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'd0; fault_clr = 1'b0;
   endtask

   task automatic op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic clr);
      exp_t e;
      @(posedge clk);
      if (p_v) apply_pending();
      #1;
      addr = a; wdata = wd; mem_read = rd; mem_write = wr; funct3 = f3; fault_clr = clr;
      e.nm  = nm;
      e.mis = f_mis(rd, wr, f3, a);
      e.rd  = f_load(rd, e.mis, f3, a);
      e.st  = m_sticky;
      e.fa  = m_faddr;
      q.push_back(e);
      p_v = 1'b1; p_wr = wr; p_mis = e.mis; p_clr = clr; p_f3 = f3; p_a = a; p_wd = wd;
   endtask

   // asserts reset mid-cycle, after the current cycle's outputs were sampled but before its edge
   task automatic reset_mid_cycle();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      clear_model();
      #1;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      nchecks++;
      if (act !== req) begin
         nerrors++;
         $display("FAIL %s.%s got %h want %h at %0t", nm, fld, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "rdata", rdata, e.rd);
            chk(e.nm, "misaligned", {31'h0, misaligned}, {31'h0, e.mis});
            chk(e.nm, "fault_sticky", {31'h0, fault_sticky}, {31'h0, e.st});
            chk(e.nm, "fault_addr", fault_addr, e.fa);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      nerrors++;
      $display("FAIL watchdog: run did not complete, pending=%0d", q.size());
      $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
      $finish;
   end

   initial begin : stim
      logic [2:0] wr_f3 [6];
      logic       rd, wr;
      logic [2:0] f3;
      wr_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      rst_n = 1'b0;
      drive_idle();
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      op("rst_lw0",   1, 0, 3'd2, 32'h0,  32'h0, 0);
      op("rst_lw40",  1, 0, 3'd2, 32'h40, 32'h0, 0);
      op("rst_lwfc",  1, 0, 3'd2, 32'hFC, 32'h0, 0);

      op("sw10",      0, 1, 3'd2, 32'h10, 32'h8000_00F1, 0);
      op("lb10",      1, 0, 3'd0, 32'h10, 32'h0, 0);
      op("lbu10",     1, 0, 3'd4, 32'h10, 32'h0, 0);
      op("lh12",      1, 0, 3'd1, 32'h12, 32'h0, 0);
      op("lhu12",     1, 0, 3'd5, 32'h12, 32'h0, 0);

      op("sw20",      0, 1, 3'd2, 32'h20, 32'hAABB_CCDD, 0);
      op("sb21",      0, 1, 3'd0, 32'h21, 32'h11, 0);
      op("sh22",      0, 1, 3'd1, 32'h22, 32'h2233, 0);
      op("lw20",      1, 0, 3'd2, 32'h20, 32'h0, 0);

      op("sw102_mis", 0, 1, 3'd2, 32'h102, 32'h5, 0);
      op("lw100",     1, 0, 3'd2, 32'h100, 32'h0, 0);
      op("lh3_mis",   1, 0, 3'd1, 32'h3, 32'h0, 0);
      op("idle_a",    0, 0, 3'd0, 32'h0, 32'h0, 0);
      op("clr",       0, 0, 3'd0, 32'h0, 32'h0, 1);
      op("idle_b",    0, 0, 3'd0, 32'h0, 32'h0, 0);

      op("sw100_wrap",1, 0, 3'd2, 32'h0, 32'h0, 0);
      op("sw100",     0, 1, 3'd2, 32'h100, 32'h1234, 0);
      op("lw0_alias", 1, 0, 3'd2, 32'h0, 32'h0, 0);
      op("lw_sw0",    1, 1, 3'd2, 32'h0, 32'h9, 0);
      op("lw0_after", 1, 0, 3'd2, 32'h0, 32'h0, 0);

      op("sw8_lost",  0, 1, 3'd2, 32'h8, 32'h77, 0);
      reset_mid_cycle();
      op("lw8_reset", 1, 0, 3'd2, 32'h8, 32'h0, 0);

      op("lw1_mis",   1, 0, 3'd2, 32'h1, 32'h0, 0);
      op("race_clr",  1, 0, 3'd1, 32'h5, 32'h0, 1);
      op("race_chk",  0, 0, 3'd0, 32'h0, 32'h0, 0);
      op("illegal_sbu", 0, 1, 3'd4, 32'h30, 32'hFF, 1);
      op("lw30",      1, 0, 3'd2, 32'h30, 32'h0, 0);

      for (int i = 0; i < 400; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         f3 = wr ? wr_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
         op("rand", rd, wr, f3, $urandom, $urandom, ($urandom_range(0, 7) == 0));
      end
      op("tail", 1, 0, 3'd2, 32'h0, 32'h0, 0);

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         nerrors++;
         $display("FAIL drain: %0d expectations never compared", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
      $finish;
   end

endmodule
